// File: rtl/uart_pkg.sv
// uart_pkg
// Shared types and helpers for the configurable UART transmitter and the
// planned receiver that will reuse the same baud generator.
//   tx_state_t : frame sequencer states
//   parity_t   : cfg_parity encodings (2'b11 is treated as no parity)
//   MIN_BITS / MAX_BITS_LIMIT : legal data-bit range per frame
//   cpb()      : clocks per bit from clock and baud rate
//   sat_bits() : clamps a requested data-bit count into the legal range
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } tx_state_t;

  typedef enum logic [1:0] {
    PAR_NONE = 2'b00,
    PAR_EVEN = 2'b01,
    PAR_ODD  = 2'b10
  } parity_t;

  localparam int MIN_BITS       = 5;
  localparam int MAX_BITS_LIMIT = 9;

  function automatic int cpb(input int clk_hz, input int baud);
    return clk_hz / baud;
  endfunction

  // Out-of-range requests snap to the nearest legal count; the upper bound
  // is whichever is smaller of the instance width and the protocol limit.
  function automatic logic [3:0] sat_bits(input logic [3:0] req, input int max_bits);
    int lim;
    int r;
    lim = (max_bits > MAX_BITS_LIMIT) ? MAX_BITS_LIMIT : max_bits;
    r   = int'(req);
    if (r < MIN_BITS) begin
      r = MIN_BITS;
    end else if (r > lim) begin
      r = lim;
    end
    return 4'(r);
  endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// uart_baud_gen
// Clocks-per-bit counter with a one-cycle bit_tick on the cycle the count
// sits at CPB-1, i.e. the tick marks the edge on which the count wraps.
// Ports:
//   clk      : system clock, rising edge
//   rst_n    : synchronous active-low reset, count returns to 0
//   clear    : restart the bit period (count to 0), wins over enable
//   enable   : count advances only while high, otherwise it holds
//   bit_tick : high for the last cycle of each bit period
module uart_baud_gen #(
  parameter int CPB = 10
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic bit_tick
);

  localparam int CNT_W = (CPB > 1) ? $clog2(CPB) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(CPB - 1);

  logic [CNT_W-1:0] cnt;

  // Free-running modulo-CPB counter; clear re-aligns the bit period so the
  // first bit after a restart is a full CPB clocks long.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (enable) begin
      cnt <= (cnt == LAST) ? '0 : cnt + 1'b1;
    end
  end

  assign bit_tick = enable && !clear && (cnt == LAST);

endmodule

// File: rtl/uart_tx_cfg.sv
// uart_tx_cfg
// Runtime-configurable UART transmitter: 5..9 data bits LSB first, optional
// even/odd parity, 1 or 2 stop bits. Configuration and data are captured on
// the accept edge, so changing cfg_* mid-frame only affects later frames.
// Optional line-break support is compiled in with `define UART_TX_BREAK_EN.
// Ports:
//   clk, rst_n      : clock, synchronous active-low reset
//   tx_break        : (UART_TX_BREAK_EN only) hold line low while idle
//   tx_valid/ready  : word handshake, transfer when both high at an edge
//   tx_data         : word, bits at or above the data-bit count are ignored
//   cfg_data_bits   : data bits per frame, saturated into 5..min(9,MAX_BITS)
//   cfg_parity      : 00 none, 01 even, 10 odd, 11 none
//   cfg_stop2       : 0 one stop bit, 1 two stop bits
//   tx              : serial line, idles high
//   tx_busy         : frame in progress
//   tx_done         : one-cycle pulse as the last stop bit ends
module uart_tx_cfg
  import uart_pkg::*;
#(
  parameter int CLK_HZ    = 50_000_000,
  parameter int BAUD_RATE = 9600,
  parameter int MAX_BITS  = 9
) (
  input  logic                clk,
  input  logic                rst_n,
`ifdef UART_TX_BREAK_EN
  input  logic                tx_break,
`endif
  input  logic                tx_valid,
  output logic                tx_ready,
  input  logic [MAX_BITS-1:0] tx_data,
  input  logic [3:0]          cfg_data_bits,
  input  logic [1:0]          cfg_parity,
  input  logic                cfg_stop2,
  output logic                tx,
  output logic                tx_busy,
  output logic                tx_done
);

  localparam int CPB = cpb(CLK_HZ, BAUD_RATE);

  generate
    if (CPB < 2) begin : g_bad_cpb
      $error("uart_tx_cfg: CLK_HZ/BAUD_RATE must be at least 2");
    end
    if (MAX_BITS < MIN_BITS || MAX_BITS > MAX_BITS_LIMIT) begin : g_bad_width
      $error("uart_tx_cfg: MAX_BITS must be within 5..9");
    end
  endgenerate

  tx_state_t           state;
  logic [MAX_BITS-1:0] shift_q;
  logic [MAX_BITS-1:0] masked;
  logic [3:0]          nbits_eff;
  logic [3:0]          nbits_q;
  logic [3:0]          bit_cnt;
  logic                par_en_q;
  logic                par_bit_q;
  logic                stop2_q;
  logic                stop_cnt;
  logic                par_en_next;
  logic                par_bit_next;
  logic                accept;
  logic                bit_tick;
  logic                baud_clear;
  logic                baud_en;

`ifdef UART_TX_BREAK_EN
  logic                brk_hold;
  logic                mark_q;
`endif

  assign accept = tx_valid && tx_ready;

  // Clamp the requested width, drop data bits beyond it, and precompute the
  // parity bit from exactly the bits that will be sent.
  always_comb begin
    nbits_eff = sat_bits(cfg_data_bits, MAX_BITS);
    masked    = '0;
    for (int i = 0; i < MAX_BITS; i++) begin
      if (i < int'(nbits_eff)) begin
        masked[i] = tx_data[i];
      end
    end
    par_en_next  = (cfg_parity == PAR_EVEN) || (cfg_parity == PAR_ODD);
    par_bit_next = (^masked) ^ (cfg_parity == PAR_ODD);
  end

`ifdef UART_TX_BREAK_EN
  // The baud counter also times the mark-after-break; it is held cleared for
  // the whole break so the mark period starts aligned on release.
  assign baud_clear = accept || brk_hold;
  assign baud_en    = (state != IDLE) || mark_q;
`else
  assign baud_clear = accept;
  assign baud_en    = (state != IDLE);
`endif

  uart_baud_gen #(
    .CPB(CPB)
  ) u_baud (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear   (baud_clear),
    .enable  (baud_en),
    .bit_tick(bit_tick)
  );

  // Frame sequencer. Every output is registered; tx only changes on an
  // accept edge or a bit_tick edge so each bit lasts exactly CPB clocks.
  // At the end of a frame tx stays high and ready returns in the same cycle
  // as tx_done, so a waiting word starts on the very next edge.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      tx        <= 1'b1;
      tx_ready  <= 1'b0;
      tx_busy   <= 1'b0;
      tx_done   <= 1'b0;
      shift_q   <= '0;
      nbits_q   <= 4'd0;
      bit_cnt   <= 4'd0;
      par_en_q  <= 1'b0;
      par_bit_q <= 1'b0;
      stop2_q   <= 1'b0;
      stop_cnt  <= 1'b0;
`ifdef UART_TX_BREAK_EN
      brk_hold  <= 1'b0;
      mark_q    <= 1'b0;
`endif
    end else begin
      tx_done <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            state     <= START;
            tx        <= 1'b0;
            tx_ready  <= 1'b0;
            tx_busy   <= 1'b1;
            shift_q   <= masked;
            nbits_q   <= nbits_eff;
            par_en_q  <= par_en_next;
            par_bit_q <= par_bit_next;
            stop2_q   <= cfg_stop2;
            bit_cnt   <= 4'd0;
            stop_cnt  <= 1'b0;
          end
`ifdef UART_TX_BREAK_EN
          else if (tx_break) begin
            brk_hold <= 1'b1;
            mark_q   <= 1'b0;
            tx       <= 1'b0;
            tx_ready <= 1'b0;
          end else if (brk_hold) begin
            brk_hold <= 1'b0;
            mark_q   <= 1'b1;
            tx       <= 1'b1;
          end else if (mark_q) begin
            if (bit_tick) begin
              mark_q   <= 1'b0;
              tx_ready <= 1'b1;
            end
          end
`endif
          else begin
            tx_ready <= 1'b1;
          end
        end

        START: begin
          if (bit_tick) begin
            state   <= DATA;
            tx      <= shift_q[0];
            shift_q <= shift_q >> 1;
            bit_cnt <= 4'd0;
          end
        end

        DATA: begin
          if (bit_tick) begin
            if (bit_cnt == nbits_q - 4'd1) begin
              if (par_en_q) begin
                state <= PARITY;
                tx    <= par_bit_q;
              end else begin
                state    <= STOP;
                tx       <= 1'b1;
                stop_cnt <= 1'b0;
              end
            end else begin
              tx      <= shift_q[0];
              shift_q <= shift_q >> 1;
              bit_cnt <= bit_cnt + 4'd1;
            end
          end
        end

        PARITY: begin
          if (bit_tick) begin
            state    <= STOP;
            tx       <= 1'b1;
            stop_cnt <= 1'b0;
          end
        end

        STOP: begin
          if (bit_tick) begin
            if (stop2_q && !stop_cnt) begin
              stop_cnt <= 1'b1;
            end else begin
              state    <= IDLE;
              tx_done  <= 1'b1;
              tx_busy  <= 1'b0;
              bit_cnt  <= 4'd0;
              stop_cnt <= 1'b0;
`ifdef UART_TX_BREAK_EN
              // A break requested mid-frame takes the line once idle.
              tx_ready <= !tx_break;
`else
              tx_ready <= 1'b1;
`endif
            end
          end
        end

        default: begin
          state <= IDLE;
          tx    <= 1'b1;
        end
      endcase
    end
  end

endmodule
